// File: rtl/kick_cmd_decoder.sv
// Kick-command frame parser and kick sequencer: decodes HDR/T/~T frames from the
// byte receiver and drives kicktime/kickstart through ARM, FIRE and COOL phases.
module kick_cmd_decoder #(
    parameter logic [7:0] HDR          = 8'hA5,
    parameter int          PULSE_LEN    = 16,
    parameter int          COOLDOWN     = 1000,
    parameter int          BYTE_TIMEOUT = 5000,
    parameter int          ARM_TIMEOUT  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       done,
    output logic [7:0] kicktime,
    output logic       kickstart,
    output logic       busy,
    output logic       frame_err,
    output logic       cmd_drop,
    output logic       arm_timeout
);

    localparam int GAP_W   = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam int ARM_W   = (ARM_TIMEOUT  > 1) ? $clog2(ARM_TIMEOUT)  : 1;
    localparam int PULSE_W = (PULSE_LEN    > 1) ? $clog2(PULSE_LEN)    : 1;
    localparam int COOL_W  = (COOLDOWN     > 1) ? $clog2(COOLDOWN)     : 1;

    // Counters hold "cycles already spent"; the terminal value is one short of the limit.
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(BYTE_TIMEOUT - 1);
    localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);
    localparam logic [COOL_W-1:0]  COOL_LAST  = COOL_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        P_HUNT    = 2'd0,
        P_GOT_HDR = 2'd1,
        P_GOT_T   = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_ARM  = 2'd1,
        K_FIRE = 2'd2,
        K_COOL = 2'd3
    } kick_state_t;

    parse_state_t       pstate_r;
    kick_state_t        kstate_r;
    logic [7:0]         t_r;
    logic [GAP_W-1:0]   gap_r;
    logic [ARM_W-1:0]   arm_cnt_r;
    logic [PULSE_W-1:0] pulse_cnt_r;
    logic [COOL_W-1:0]  cool_cnt_r;
    logic [7:0]         kicktime_r;
    logic               kickstart_r;
    logic               busy_r;
    logic               frame_err_r;
    logic               cmd_drop_r;
    logic               arm_timeout_r;

    logic               good_frame_s;
    logic               bad_frame_s;
    logic               timeout_s;
    logic               kick_req_s;

    // Frame verdict for the current cycle: checksum outcome or inter-byte timeout.
    always_comb begin
        good_frame_s = 1'b0;
        bad_frame_s  = 1'b0;
        timeout_s    = 1'b0;
        if (rx_valid && (pstate_r == P_GOT_T)) begin
            if ((rx_data ^ t_r) == 8'hFF) begin
                good_frame_s = 1'b1;
            end else begin
                bad_frame_s = 1'b1;
            end
        end else if (!rx_valid && (pstate_r != P_HUNT) && (gap_r == GAP_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        kick_req_s = good_frame_s && (t_r != 8'h00);
    end

    // Byte-level parser with idle-gap watchdog; a byte arriving on the timeout cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_r    <= P_HUNT;
            t_r         <= 8'h00;
            gap_r       <= '0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= bad_frame_s | timeout_s;
            if (rx_valid) begin
                gap_r <= '0;
                case (pstate_r)
                    P_HUNT: begin
                        if (rx_data == HDR) begin
                            pstate_r <= P_GOT_HDR;
                        end
                    end
                    P_GOT_HDR: begin
                        t_r      <= rx_data;
                        pstate_r <= P_GOT_T;
                    end
                    P_GOT_T:  pstate_r <= P_HUNT;
                    default:  pstate_r <= P_HUNT;
                endcase
            end else if (pstate_r == P_HUNT) begin
                gap_r <= '0;
            end else if (timeout_s) begin
                pstate_r <= P_HUNT;
                gap_r    <= '0;
            end else begin
                gap_r <= gap_r + GAP_W'(1'b1);
            end
        end
    end

    // Kick sequencer: all outputs are registered and updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kstate_r      <= K_IDLE;
            arm_cnt_r     <= '0;
            pulse_cnt_r   <= '0;
            cool_cnt_r    <= '0;
            kicktime_r    <= 8'h00;
            kickstart_r   <= 1'b0;
            busy_r        <= 1'b0;
            cmd_drop_r    <= 1'b0;
            arm_timeout_r <= 1'b0;
        end else begin
            cmd_drop_r    <= kick_req_s && (kstate_r != K_IDLE);
            arm_timeout_r <= 1'b0;
            case (kstate_r)
                K_IDLE: begin
                    if (kick_req_s) begin
                        kicktime_r <= t_r;
                        kstate_r   <= K_ARM;
                        busy_r     <= 1'b1;
                        arm_cnt_r  <= '0;
                    end
                end
                K_ARM: begin
                    if (done) begin
                        kstate_r    <= K_FIRE;
                        kickstart_r <= 1'b1;
                        pulse_cnt_r <= '0;
                    end else if (arm_cnt_r == ARM_LAST) begin
                        arm_timeout_r <= 1'b1;
                        kicktime_r    <= 8'h00;
                        kstate_r      <= K_IDLE;
                        busy_r        <= 1'b0;
                    end else begin
                        arm_cnt_r <= arm_cnt_r + ARM_W'(1'b1);
                    end
                end
                K_FIRE: begin
                    if (pulse_cnt_r == PULSE_LAST) begin
                        kstate_r    <= K_COOL;
                        kickstart_r <= 1'b0;
                        kicktime_r  <= 8'h00;
                        cool_cnt_r  <= '0;
                    end else begin
                        pulse_cnt_r <= pulse_cnt_r + PULSE_W'(1'b1);
                    end
                end
                K_COOL: begin
                    if (cool_cnt_r == COOL_LAST) begin
                        kstate_r <= K_IDLE;
                        busy_r   <= 1'b0;
                    end else begin
                        cool_cnt_r <= cool_cnt_r + COOL_W'(1'b1);
                    end
                end
                default: begin
                    kstate_r    <= K_IDLE;
                    kickstart_r <= 1'b0;
                    kicktime_r  <= 8'h00;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign kicktime    = kicktime_r;
    assign kickstart   = kickstart_r;
    assign busy        = busy_r;
    assign frame_err   = frame_err_r;
    assign cmd_drop    = cmd_drop_r;
    assign arm_timeout = arm_timeout_r;

endmodule

// File: doc/kick_cmd_decoder.md
Name: kick_cmd_decoder

Overview:
- Upstream stage of the kicker. Parses kick-command frames from the radio/UART byte receiver and drives the kicker's `kicktime` and `kickstart` inputs.
- Arms a kick only after the capacitor-charged flag `done` is high, holds `kickstart` for a fixed pulse, then enforces a cooldown.
- Rejects malformed, stale or overlapping commands and flags each rejection on a status pulse.

Parameters:
- HDR, 8'hA5, frame header byte.
- PULSE_LEN, 16, cycles `kickstart` is held high (≥1).
- COOLDOWN, 1000, cycles after a pulse before a new kick is accepted (≥1).
- BYTE_TIMEOUT, 5000, maximum idle cycles between bytes of one frame.
- ARM_TIMEOUT, 100000, maximum cycles spent waiting for `done`.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only while `rx_valid` is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- done  in  1  capacitor-charged flag from the charge circuit.
- kicktime  out  8  kick duration to the kicker.
- kickstart  out  1  kick request to the kicker.
- busy  out  1  high whenever the kick FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse on checksum failure or byte timeout.
- cmd_drop  out  1  one-cycle pulse when a good frame arrives while busy.
- arm_timeout  out  1  one-cycle pulse when `done` never arrived.

Behaviour:
- Reset (asynchronous, `rst_n` low):
  - all outputs go to 0;
  - parser returns to HUNT; kick FSM returns to IDLE;
  - all counters clear.
- A reset mid-kick drops `kickstart` immediately, with no cooldown.
- Frame format: 3 bytes. `HDR`, then T, then C. The frame is good iff C == ~T.
- Parser states (advance only on `rx_valid`):
  - HUNT: byte == `HDR` → GOT_HDR; any other byte is ignored silently.
  - GOT_HDR: capture the byte as T (T may equal `HDR`) → GOT_T.
  - GOT_T: C == ~T → good frame, back to HUNT. Otherwise `frame_err` pulses and the parser returns to HUNT; the failing byte is not re-examined as a header.
- Byte timeout:
  - the gap counter clears on every `rx_valid`;
  - in GOT_HDR or GOT_T, reaching `BYTE_TIMEOUT` idle cycles pulses `frame_err` and returns the parser to HUNT;
  - a `rx_valid` in the same cycle as the timeout wins.
- Good-frame dispatch, evaluated in the cycle of the last byte:
  - kick FSM IDLE and T != 0: `kicktime` <= T and FSM → ARM, both visible the next cycle;
  - T == 0: accepted as a no-kick; no state change, no pulse;
  - kick FSM not IDLE: `cmd_drop` pulses the next cycle; `kicktime` and state are unchanged.
- Kick FSM states:
  - IDLE: `kickstart` = 0, `busy` = 0.
  - ARM: wait counter runs. If `done` = 1 → FIRE next cycle. If the counter reaches `ARM_TIMEOUT` first, `arm_timeout` pulses, `kicktime` <= 0 and FSM → IDLE. `done` wins if both occur in the same cycle.
  - FIRE: `kickstart` = 1 for exactly `PULSE_LEN` consecutive cycles, with `kicktime` held stable. Deassertion of `done` during FIRE is ignored. Then → COOL.
  - COOL: `kickstart` = 0 and `kicktime` = 0 from the first COOL cycle. After exactly `COOLDOWN` cycles → IDLE.
- Latency: last frame byte at cycle N, `done` already high → ARM at N+1, `kickstart` first high at N+2, last high at N+1+`PULSE_LEN`.
- Outputs `kickstart`, `kicktime` and the status pulses are registered. `busy` is a registered decode of state.
- Counters are sized by $clog2 of their parameter and never wrap. Each clears on every entry to its state.
- The parser runs independently of the kick FSM, so frames are parsed and checked even while busy.

Test Plan:
- Happy path: `done` = 1; bytes A5, 7F, 80 on consecutive strobes → `kicktime` = 7F one cycle after the 80; `kickstart` high for 16 cycles starting the following cycle; `busy` stays high until 1000 cycles after `kickstart` falls; `kicktime` = 0 in COOL.
- Delayed charge: `done` = 0; frame A5, FF, 00; raise `done` 300 cycles later → `kickstart` rises the cycle after `done`, no `arm_timeout`. Repeat with ARM_TIMEOUT = 50 and `done` never raised → `arm_timeout` pulse 50 cycles into ARM; `kicktime` = 0, `busy` = 0.
- Bad frames: A5, 10, 10 → `frame_err` single pulse, no kick. A5, then a 5000-cycle gap, then 10, EF → `frame_err` at the timeout; the trailing 10, EF produce nothing. Junk bytes 00, 33 before a good frame → ignored, kick proceeds.
- Overlap: a second good frame A5, 20, DF during FIRE → `cmd_drop` pulse; `kicktime` stays 7F; no second kick after cooldown.
- Edge data: A5, A5, 5A → valid frame, kick with T = A5. A5, 00, FF → accepted, no `kickstart`, no pulses.
- Reset mid-FIRE: pull `rst_n` low on pulse cycle 5 → `kickstart`, `kicktime` and `busy` drop to 0 without waiting for a clock edge; after release a fresh frame kicks normally with no cooldown wait.
